uart_rx_frame: RTL and testbench

//  UART receiver for the serial line. It is the counterpart of the existing 8N1 transmitter.
//  It synchronises rs232_rx, detects the start-bit falling edge and requests bit ticks from the

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 49 ++++
 rtl/uart_rx_frame.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Package     : uart_pkg
// Description : Shared definitions for the UART receiver and transmitter:
//               receive FSM state encoding, idle line level, default width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Default number of data bits in a frame
    localparam int UART_DATA_BITS = 8;

    // Level of the serial line when nothing is being sent (mark)
    localparam logic UART_IDLE_LVL = 1'b1;

    // Receive FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Multi-stage synchroniser for the asynchronous serial input,
//               followed by a registered falling-edge detector.
// Ports       : clk      in  system clock
//               rst      in  asynchronous active-high reset
//               rs232_rx in  raw serial line (asynchronous to clk)
//               rx_s     out synchronised line level
//               rx_fall  out high for one clk when rx_s goes 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rs232_rx,
    output logic rx_s,
    output logic rx_fall
);

    // Fewer than two stages gives no metastability protection
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              rx_prev;

    // Reset to the idle level so that reset release never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {STAGES{UART_IDLE_LVL}};
            rx_prev <= UART_IDLE_LVL;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], rs232_rx};
            rx_prev <= sync_q[STAGES-1];
        end
    end

    assign rx_s    = sync_q[STAGES-1];
    // Both terms come straight from flops, so the pulse is glitch-free
    assign rx_fall = rx_prev & ~rx_s;

endmodule : uart_rx_sync

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module      : uart_rx_frame
// Description : UART frame receiver. Detects the start edge, enables the
//               shared baud generator, samples each bit on the mid-bit
//               clk_bps pulse (LSB first) and delivers the byte together
//               with framing/parity status.
// Ports       : clk        in  system clock
//               rst        in  asynchronous active-high reset
//               rs232_rx   in  serial line, idle high
//               clk_bps    in  mid-bit tick from the baud generator
//               bps_start  out baud generator enable (frame in progress)
//               rx_data    out last received byte
//               rx_int     out busy; falling edge marks data ready
//               rx_valid   out one-clk pulse when rx_data is updated
//               frame_err  out stop bit of last frame was 0
//               parity_err out parity mismatch on last frame
// Config      : UART_RX_PARITY_EN - when defined, a parity bit follows the
//               data bits and is checked (sense set by PARITY_ODD);
//               otherwise 8N1 framing and parity_err is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rs232_rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_int,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int                 CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_s;
    logic                 rx_fall;
    logic                 start_pend;
    logic                 start_req;
    logic                 stop_done;

    // ------------------------------------------------------------------
    // Input synchroniser and start-edge detector
    // ------------------------------------------------------------------
    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rs232_rx (rs232_rx),
        .rx_s     (rx_s),
        .rx_fall  (rx_fall)
    );

    // An edge that lands in the cycle the stop bit is taken is held for
    // one clk so the FSM, back in IDLE, still starts on it.
    assign start_req = rx_fall | start_pend;
    assign stop_done = (state == ST_STOP) && clk_bps;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Only clk_bps advances a frame; IDLE ignores it.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (clk_bps) begin
                    // A high line at mid start bit means the edge was a glitch
                    state_nxt = (rx_s == UART_IDLE_LVL) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_bps && (bit_cnt == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (clk_bps) begin
                    state_nxt = ST_STOP;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (clk_bps) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Busy and baud enable cover every non-idle state, so
    // both drop in the same clk that rx_valid pulses.
    // ------------------------------------------------------------------
    always_comb begin
        bps_start = (state != ST_IDLE);
        rx_int    = (state != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath: bit index, shift register, delivered byte and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
            rx_valid   <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            rx_valid   <= stop_done;
            start_pend <= stop_done & rx_fall;

            if ((state == ST_START) && clk_bps) begin
                bit_cnt <= '0;
            end

            if ((state == ST_DATA) && clk_bps) begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (bit_cnt == CNT_W'(i)) begin
                        shift_reg[i] <= rx_s;
                    end
                end
                // Hold at the last index; START clears it for the next frame
                if (bit_cnt != LAST_IDX) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            // The byte is delivered even when the stop bit is bad
            if (stop_done) begin
                rx_data   <= shift_reg;
                frame_err <= ~rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // ------------------------------------------------------------------
    // Parity capture and check, published together with rx_data
    // ------------------------------------------------------------------
    logic par_bit;
    logic parity_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if ((state == ST_PARITY) && clk_bps) begin
                par_bit <= rx_s;
            end
            if (stop_done) begin
                parity_err_q <= ((^shift_reg) ^ par_bit) != PARITY_ODD;
            end
        end
    end

    assign parity_err = parity_err_q;
`else
    // No parity bit in the frame; the sense parameter has nothing to act on
    assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule : uart_rx_frame

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Self-checking bench for uart_rx_frame. A baud-generator model
//               pulses clk_bps mid-bit (16 clk per bit) while bps_start is
//               high; frames are driven on rs232_rx and the delivered bytes
//               are compared with a frame-level reference model.
// Config      : UART_RX_PARITY_EN - adds the parity bit to driven frames and
//               the parity scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    localparam int DB         = 8;
    localparam int BIT_CLKS   = 16;
    localparam bit PAR_ODD    = 1'b0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rs232_rx = 1'b1;
    logic          clk_bps = 1'b0;
    logic          bps_start;
    logic [DB-1:0] rx_data;
    logic          rx_int;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_frame #(
        .DATA_BITS   (DB),
        .SYNC_STAGES (2),
        .PARITY_ODD  (PAR_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs232_rx   (rs232_rx),
        .clk_bps    (clk_bps),
        .bps_start  (bps_start),
        .rx_data    (rx_data),
        .rx_int     (rx_int),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Baud generator model: free-running 16-clk bit timer, tick at count 7
    int baud_cnt = 0;
    always @(negedge clk) begin
        if (!bps_start) begin
            baud_cnt = 0;
            clk_bps  = 1'b0;
        end else begin
            clk_bps  = (baud_cnt == 7);
            baud_cnt = (baud_cnt == BIT_CLKS - 1) ? 0 : baud_cnt + 1;
        end
    end

    // Monitor: record each delivered frame and count busy cycles
    typedef struct {
        logic [DB-1:0] d;
        logic          fe;
        logic          pe;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   int_cycles = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back('{d: rx_data, fe: frame_err, pe: parity_err});
        end
        if (rx_int) begin
            int_cycles++;
        end
    end

    // Correct parity bit for a data word under the configured sense
    function automatic logic good_par(input logic [DB-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    // Expected parity_err when the bit sent is 'p'
    function automatic logic exp_pe(input logic [DB-1:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
        return p != good_par(d);
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rs232_rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Start, data LSB first, optional parity, stop. Line is left at the stop level.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par !== par) rs232_rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bps_start, rx_int, rx_valid, frame_err, parity_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bps_start, rx_int, rx_valid, frame_err, parity_err});
        end
        n_checks++;
        if (rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00", rx_data);
        end
        rst = 1'b0;
        idle(10);
        n_checks++;
        if (rx_int !== 1'b0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: rx_int=%b frames=%0d expected 0/0", rx_int, got_q.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic();
        got_q.delete();
        idle(5);
        int_cycles = 0;
        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        idle(20);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d frames expected 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].d !== 8'hA5) begin
                n_fail++;
                $display("FAIL basic_data: got %h expected a5", got_q[0].d);
            end
            n_checks++;
            if (got_q[0].fe !== 1'b0 || got_q[0].pe !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_err: got fe=%b pe=%b expected 0/0", got_q[0].fe, got_q[0].pe);
            end
        end
        n_checks++;
        if (int_cycles < 140 || int_cycles > 180) begin
            n_fail++;
            $display("FAIL basic_busy: rx_int high %0d clk expected about 160", int_cycles);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_glitch();
        got_q.delete();
        idle(5);
        int_cycles = 0;
        rs232_rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        n_checks++;
        if (int_cycles < 1 || int_cycles > 20) begin
            n_fail++;
            $display("FAIL glitch_busy: rx_int high %0d clk expected short pulse", int_cycles);
        end
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_valid: got %0d frames expected 0", got_q.size());
        end
        n_checks++;
        if (rx_data !== 8'hA5 || rx_int !== 1'b0 || bps_start !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_hold: data=%h int=%b bps=%b expected a5/0/0",
                     rx_data, rx_int, bps_start);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_break();
        got_q.delete();
        idle(5);
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        int_cycles = 0;
        rs232_rx = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL break_count: got %0d frames expected 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].d !== 8'h3C || got_q[0].fe !== 1'b1) begin
                n_fail++;
                $display("FAIL break_frame: got data=%h fe=%b expected 3c/1", got_q[0].d, got_q[0].fe);
            end
        end
        n_checks++;
        if (int_cycles != 0) begin
            n_fail++;
            $display("FAIL break_rearm: rx_int high %0d clk on held-low line expected 0", int_cycles);
        end
        got_q.delete();
        idle(5);
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        idle(20);
        n_checks++;
        if (got_q.size() != 1 || got_q[0].d !== 8'h5A || got_q[0].fe !== 1'b0) begin
            n_fail++;
            $display("FAIL break_recover: frames=%0d data=%h fe=%b expected 1/5a/0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].d : 8'hxx,
                     (got_q.size() > 0) ? got_q[0].fe : 1'bx);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        bit seen;
        got_q.delete();
        idle(5);
        // First frame driven bit by bit so the second start can follow the stop sample
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(1'b0);
`ifdef UART_RX_PARITY_EN
        send_bit(good_par(8'h00));
`endif
        rs232_rx = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (rx_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL b2b_first_timeout: rx_valid not seen within 40 clk");
        end
        // rx_valid is one clk after the stop sample
        repeat (7) @(negedge clk);
        send_frame(8'hFF, 1'b1, good_par(8'hFF));
        idle(20);
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d frames expected 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].d !== 8'h00 || got_q[1].d !== 8'hFF) begin
                n_fail++;
                $display("FAIL b2b_data: got %h,%h expected 00,ff", got_q[0].d, got_q[1].d);
            end
            n_checks++;
            if (got_q[0].fe !== 1'b0 || got_q[1].fe !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_fe: got %b,%b expected 0,0", got_q[0].fe, got_q[1].fe);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        got_q.delete();
        idle(5);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rs232_rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bps_start, rx_int, rx_valid, frame_err, parity_err} !== 5'b0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: ctrl=%b data=%h expected 00000/00",
                     {bps_start, rx_int, rx_valid, frame_err, parity_err}, rx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        n_checks++;
        if (got_q.size() != 0 || rx_int !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_discard: frames=%0d rx_int=%b expected 0/0", got_q.size(), rx_int);
        end
        send_frame(8'h81, 1'b1, good_par(8'h81));
        idle(20);
        n_checks++;
        if (got_q.size() != 1 || got_q[0].d !== 8'h81) begin
            n_fail++;
            $display("FAIL midrst_next: frames=%0d data=%h expected 1/81",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].d : 8'hxx);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic [DB-1:0] d;
        logic          stop;
        logic          flip;
        logic          p;
        got_q.delete();
        exp_q.delete();
        idle(5);
        for (int n = 0; n < 12; n++) begin
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            flip = ($urandom_range(0, 2) == 0);
            p    = good_par(d) ^ flip;
            exp_q.push_back('{d: d, fe: ~stop, pe: exp_pe(d, p)});
            send_frame(d, stop, p);
            idle($urandom_range(2, 20));
        end
        idle(20);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d frames expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int n = 0; n < exp_q.size(); n++) begin
                n_checks++;
                if (got_q[n].d !== exp_q[n].d || got_q[n].fe !== exp_q[n].fe ||
                    got_q[n].pe !== exp_q[n].pe) begin
                    n_fail++;
                    $display("FAIL rand_frame%0d: got %h/fe%b/pe%b expected %h/fe%b/pe%b", n,
                             got_q[n].d, got_q[n].fe, got_q[n].pe,
                             exp_q[n].d, exp_q[n].fe, exp_q[n].pe);
                end
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    // ------------------------------------------------------------------
    task automatic test_parity();
        got_q.delete();
        idle(5);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL parity_count: got %0d frames expected 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].pe !== 1'b0 || got_q[0].d !== 8'h07) begin
                n_fail++;
                $display("FAIL parity_good: got pe=%b data=%h expected 0/07", got_q[0].pe, got_q[0].d);
            end
            n_checks++;
            if (got_q[1].pe !== 1'b1 || got_q[1].d !== 8'h07) begin
                n_fail++;
                $display("FAIL parity_bad: got pe=%b data=%h expected 1/07", got_q[1].pe, got_q[1].d);
            end
        end
    endtask
`endif

    // Watchdog: a hang is reported and ends the run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_frame

`default_nettype wire
